// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer: loads a clamped preset, decrements once per
// tick while running, and latches a sticky expired state at 00:00.
module countdown_timer #(
  parameter int MW      = 6,
  parameter int MAX_MIN = 59
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          load,
  input  logic [MW-1:0] load_min,
  input  logic [5:0]    load_sec,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  output logic [MW-1:0] min,
  output logic [5:0]    sec,
  output logic          running,
  output logic          expired,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t        state, state_nxt;
  logic [MW-1:0] min_nxt;
  logic [5:0]    sec_nxt;
  logic          done_nxt;

  function automatic logic [MW-1:0] sat_min(input logic [MW-1:0] v);
    if (v > MW'(MAX_MIN)) return MW'(MAX_MIN);
    else                  return v;
  endfunction

  function automatic logic [5:0] sat_sec(input logic [5:0] v);
    if (v > 6'd59) return 6'd59;
    else           return v;
  endfunction

  // Only the highest-priority active event acts on a given edge.
  always_comb begin
    state_nxt = state;
    min_nxt   = min;
    sec_nxt   = sec;
    done_nxt  = 1'b0;
    if (load) begin
      min_nxt   = sat_min(load_min);
      sec_nxt   = sat_sec(load_sec);
      state_nxt = IDLE;
    end else if (clear) begin
      min_nxt   = '0;
      sec_nxt   = '0;
      state_nxt = IDLE;
    end else if (stop) begin
      if (state == RUN) state_nxt = PAUSED;
    end else if (start) begin
      if ((state == PAUSED) || ((state == IDLE) && ((min != '0) || (sec != '0))))
        state_nxt = RUN;
    end else if (tick && (state == RUN)) begin
      if (sec != '0) begin
        sec_nxt = sec - 6'd1;
      end else begin
        min_nxt = min - MW'(1);
        sec_nxt = 6'd59;
      end
      // A borrow always lands on xx:59, so only 00:01 can reach zero.
      if ((min == '0) && (sec == 6'd1)) begin
        state_nxt = EXPIRED;
        done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      min   <= '0;
      sec   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      min   <= min_nxt;
      sec   <= sec_nxt;
      done  <= done_nxt;
    end
  end

  assign running = (state == RUN);
  assign expired = (state == EXPIRED);

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Minutes:seconds countdown timer for the alarm clock datapath; it is the decrementing counterpart of the existing modulo-N up counters. It loads a preset, then counts down one second per `tick` pulse, borrowing from minutes into seconds. At 00:00 it enters a sticky expired state that drives the alarm/buzzer logic until cleared or reloaded. `tick` comes from the shared 1 Hz enable generator, so the block runs entirely in the `clk` domain.

## Interface
- `MW`, 6, width of the minutes field
- `MAX_MIN`, 59, largest loadable minutes value; must be less than 2^MW
- `clk` input 1: system clock; all state changes on its rising edge
- `rst` input 1: synchronous, active-low reset (one clock; reset is synchronous and active-low)
- `tick` input 1: one-cycle 1 Hz enable pulse
- `load` input 1: load preset from `load_min`/`load_sec`
- `load_min` input MW: preset minutes
- `load_sec` input 6: preset seconds
- `start` input 1: begin or resume counting
- `stop` input 1: pause counting
- `clear` input 1: abort; zero the count and acknowledge expiry
- `min` output MW: current minutes, registered
- `sec` output 6: current seconds, registered, range 0..59
- `running` output 1: high while in RUN
- `expired` output 1: high while in EXPIRED (sticky)
- `done` output 1: one-cycle pulse on the RUN→EXPIRED transition

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED.
- Per-edge priority: `rst` low > `load` > `clear` > `stop` > `start` > `tick`. Only the highest-priority active event acts.
- `load` (any state):
  - `min` ← min(`load_min`, MAX_MIN); `sec` ← min(`load_sec`, 59).
  - State → IDLE. Clears `expired`.
- `clear` (any state): `min`/`sec` ← 0; state → IDLE.
- `start`:
  - IDLE with count ≠ 00:00 → RUN.
  - PAUSED → RUN.
  - Ignored in IDLE with count 00:00, in RUN, and in EXPIRED.
- `stop`: RUN → PAUSED; ignored in all other states.
- `tick` in RUN:
  - `sec` > 0: `sec` − 1.
  - `sec` = 0 and `min` > 0: `min` − 1, `sec` ← 59 (borrow).
  - If the new value is 00:00: state → EXPIRED and `done` = 1 for exactly one cycle.
- `tick` outside RUN is ignored; the count holds.
- `running` = (state == RUN); `expired` = (state == EXPIRED).
- All arithmetic is unsigned. No underflow is possible, because RUN is never entered at 00:00 and the machine leaves RUN on reaching 00:00.

## Timing
- Reset: after `rst` is sampled low on an edge, state = IDLE, `min` = 0, `sec` = 0, `running` = 0, `expired` = 0, `done` = 0. Reset mid-count discards the count.
- All outputs are registered and update on the same edge that samples the causing input (latency 1 clock, no combinational paths from inputs to outputs).
- `start` and `tick` on the same edge: the block enters RUN without decrementing. The first decrement happens on the next `tick`.
- `stop` and `tick` on the same edge: the block pauses without decrementing.
- `start` and `stop` on the same edge: `stop` wins (RUN→PAUSED; other states unchanged).
- `load` during RUN with a simultaneous `tick`: the preset is loaded, the tick is dropped, and the state becomes IDLE.
- 00:01 + `tick`: the edge yields 00:00, EXPIRED, and `done` high. `done` is low on the next edge regardless of inputs.
- `done` is never asserted by `load`, `clear`, or reset.
- EXPIRED holds until `load`, `clear`, or reset; `tick` and `start` have no effect there.

## Test plan
- Reset then load: `rst` low for 2 cycles, then `load` with 2:05 → `min`=2, `sec`=5, `running`=0, `expired`=0.
- Borrow and expiry:
  - Load 1:01, `start`, then apply 61 ticks.
  - Expect 1:00 after tick 1, 0:59 after tick 2, and 0:00 after tick 61.
  - On tick 61: `done` pulses for one cycle and `expired` stays high.
- Pause/resume and simultaneity:
  - Load 0:10 and `start`. Apply 3 ticks → 0:07.
  - `stop`+`tick` on the same edge → 0:07, PAUSED.
  - 5 ticks while paused → still 0:07.
  - `start`+`tick` on the same edge → RUN, still 0:07. Next tick → 0:06.
- Clamping and zero start:
  - `load_min`=63, `load_sec`=63 → 59:59.
  - `clear` → 0:00, IDLE. `start` → stays IDLE, `running`=0.
- Priority and mid-run reset:
  - During RUN at 3:00, `load` 0:30 with `clear` and `tick` on the same edge → 0:30, IDLE.
  - `start`, 2 ticks, then `rst` low → 0:00, IDLE, `done`=0.
- Expiry hold:
  - After expiry, apply 10 ticks plus `start` → `expired` stays 1 and the count stays 0:00.
  - `clear` → `expired`=0.
